// File: rtl/yutorina_decode_pkg.sv
// Shared decode definitions: field positions, opcode map, active-low enable
// levels and the ID/EX bubble control value.
package yutorina_decode_pkg;

   localparam int WORD_W = 32;
   localparam int REG_AW = 5;
   localparam int OP_W   = 6;

   localparam int OP_LSB = 26;
   localparam int RA_LSB = 21;
   localparam int RB_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int IMM_W  = 16;

   localparam logic [5:0] OP_R       = 6'h00;
   localparam logic [5:0] OP_ALUI_LO = 6'h01;
   localparam logic [5:0] OP_ALUI_HI = 6'h0F;
   localparam logic [5:0] OP_LOAD    = 6'h10;
   localparam logic [5:0] OP_STORE   = 6'h11;
   localparam logic [5:0] OP_BR_LO   = 6'h12;
   localparam logic [5:0] OP_BR_HI   = 6'h13;

   localparam logic WE_ON  = 1'b0;
   localparam logic WE_OFF = 1'b1;

   typedef enum logic [2:0] {
      CLS_R, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_NOP
   } insn_class_e;

   typedef struct packed {
      logic valid;
      logic we_;
      logic mem_read;
      logic mem_write;
   } idex_ctl_t;

   localparam idex_ctl_t CTL_BUBBLE = '{valid: 1'b0, we_: WE_OFF, mem_read: 1'b0, mem_write: 1'b0};

   function automatic insn_class_e classify(input logic [5:0] op);
      if (op == OP_R)                           return CLS_R;
      if (op >= OP_ALUI_LO && op <= OP_ALUI_HI) return CLS_ALUI;
      if (op == OP_LOAD)                        return CLS_LOAD;
      if (op == OP_STORE)                       return CLS_STORE;
      if (op >= OP_BR_LO && op <= OP_BR_HI)     return CLS_BRANCH;
      return CLS_NOP;
   endfunction

endpackage

// File: rtl/yutorina_operand_forward.sv
// One source operand: compares the source register against the EX and MEM
// destinations and, when forwarding is built in, picks the newest value.
module yutorina_operand_forward
   import yutorina_decode_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_AW = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic [REG_AW-1:0] src,
   input  logic              ex_en,
   input  logic              ex_fwd_ok,
   input  logic [REG_AW-1:0] ex_wa,
   input  logic [WORD_W-1:0] ex_data,
   input  logic              mem_en,
   input  logic [REG_AW-1:0] mem_wa,
   input  logic [WORD_W-1:0] mem_data,
   input  logic [WORD_W-1:0] gpr_data,
   output logic [WORD_W-1:0] operand,
   output logic              ex_match,
   output logic              mem_match
);

   // $0 never matches: it is hard-wired and never has a pending write
   assign ex_match  = ex_en  && (src != '0) && (src == ex_wa);
   assign mem_match = mem_en && (src != '0) && (src == mem_wa);

   always_comb begin
      operand = gpr_data;
      if (FWD_EN) begin
         if (ex_match && ex_fwd_ok) operand = ex_data;
         else if (mem_match)        operand = mem_data;
      end
   end

endmodule

// File: rtl/yutorina_decode_stage.sv
// Decode / operand-fetch stage feeding the ID/EX register.
// Build option YUTORINA_DECODE_FORWARD_EN: EX/MEM forwarding; otherwise RAW stalls.
module yutorina_decode_stage
   import yutorina_decode_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_AW = 5,
   parameter int OP_W   = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [WORD_W-1:0] if_pc,
   input  logic [WORD_W-1:0] if_insn,
   output logic [REG_AW-1:0] gpr_addr0,
   input  logic [WORD_W-1:0] gpr_data0,
   output logic [REG_AW-1:0] gpr_addr1,
   input  logic [WORD_W-1:0] gpr_data1,
   input  logic [WORD_W-1:0] ex_result,
   input  logic              mem_we_,
   input  logic [REG_AW-1:0] mem_wa,
   input  logic [WORD_W-1:0] mem_wd,
   input  logic              stall_in,
   input  logic              flush,
   output logic              id_stall,
   output logic              id_valid,
   output logic [WORD_W-1:0] id_pc,
   output logic [OP_W-1:0]   id_op,
   output logic [WORD_W-1:0] id_a,
   output logic [WORD_W-1:0] id_b,
   output logic [WORD_W-1:0] id_imm,
   output logic [REG_AW-1:0] id_wa,
   output logic              id_we_,
   output logic              id_mem_read,
   output logic              id_mem_write
);

`ifdef YUTORINA_DECODE_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic [OP_W-1:0]   op;
   logic [REG_AW-1:0] ra, rb, rd;
   logic [IMM_W-1:0]  imm;

   assign op  = if_insn[OP_LSB +: OP_W];
   assign ra  = if_insn[RA_LSB +: REG_AW];
   assign rb  = if_insn[RB_LSB +: REG_AW];
   assign rd  = if_insn[RD_LSB +: REG_AW];
   assign imm = if_insn[IMM_W-1:0];

   assign gpr_addr0 = ra;
   assign gpr_addr1 = rb;

   insn_class_e       cls;
   logic              reads_a, reads_b, writes;
   logic [REG_AW-1:0] dst;

   always_comb begin
      cls     = classify(op);
      reads_a = (cls != CLS_NOP);
      reads_b = (cls == CLS_R) || (cls == CLS_STORE) || (cls == CLS_BRANCH);
      writes  = 1'b0;
      dst     = '0;
      case (cls)
         CLS_R:              begin writes = 1'b1; dst = rd; end
         CLS_ALUI, CLS_LOAD: begin writes = 1'b1; dst = rb; end
         default:            ;
      endcase
   end

   logic              ex_en, mem_en;
   logic [WORD_W-1:0] opnd_a, opnd_b;
   logic              ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

   assign ex_en  = id_valid && (id_we_ == WE_ON);
   assign mem_en = (mem_we_ == WE_ON);

   yutorina_operand_forward #(.WORD_W(WORD_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
      .src(ra), .ex_en(ex_en), .ex_fwd_ok(!id_mem_read), .ex_wa(id_wa), .ex_data(ex_result),
      .mem_en(mem_en), .mem_wa(mem_wa), .mem_data(mem_wd), .gpr_data(gpr_data0),
      .operand(opnd_a), .ex_match(ex_hit_a), .mem_match(mem_hit_a)
   );

   yutorina_operand_forward #(.WORD_W(WORD_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
      .src(rb), .ex_en(ex_en), .ex_fwd_ok(!id_mem_read), .ex_wa(id_wa), .ex_data(ex_result),
      .mem_en(mem_en), .mem_wa(mem_wa), .mem_data(mem_wd), .gpr_data(gpr_data1),
      .operand(opnd_b), .ex_match(ex_hit_b), .mem_match(mem_hit_b)
   );

   // Without forwarding any pending write to a read source must drain first
   logic use_a, use_b, hazard;

   assign use_a  = reads_a && (FWD_EN ? (ex_hit_a && id_mem_read) : (ex_hit_a || mem_hit_a));
   assign use_b  = reads_b && (FWD_EN ? (ex_hit_b && id_mem_read) : (ex_hit_b || mem_hit_b));
   assign hazard = if_valid && (use_a || use_b);

   assign id_stall = hazard || stall_in;

   // ID/EX register: reset and bubble share the same image
   always_ff @(posedge clock) begin
      if (!reset || flush || (!stall_in && (hazard || !if_valid))) begin
         id_valid     <= CTL_BUBBLE.valid;
         id_we_       <= CTL_BUBBLE.we_;
         id_mem_read  <= CTL_BUBBLE.mem_read;
         id_mem_write <= CTL_BUBBLE.mem_write;
         id_pc        <= '0;
         id_op        <= '0;
         id_a         <= '0;
         id_b         <= '0;
         id_imm       <= '0;
         id_wa        <= '0;
      end else if (!stall_in) begin
         id_valid     <= 1'b1;
         id_we_       <= (writes && dst != '0) ? WE_ON : WE_OFF;
         id_mem_read  <= (cls == CLS_LOAD);
         id_mem_write <= (cls == CLS_STORE);
         id_pc        <= if_pc;
         id_op        <= op;
         id_a         <= opnd_a;
         id_b         <= opnd_b;
         id_imm       <= {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
         id_wa        <= dst;
      end
   end

endmodule
